sprite_rom_arbiter: RTL

//  Shares the single read port of the sprite-pixel ROM between the player-1 and player-2 sprite renderers.

---
 rtl/sprite_rom_arbiter_if.sv | 32 +++
 rtl/sprite_rom_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter_if.sv
// Sprite ROM arbiter bus: renderer requests/grants, ROM read port and tagged return data.
interface sprite_rom_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              req1;
    logic [ADDR_W-1:0] base1;
    logic              req2;
    logic [ADDR_W-1:0] base2;
    logic              gnt1;
    logic              gnt2;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid1;
    logic              rd_valid2;
    logic              rd_last;
    logic              busy;

    // Renderers and ROM side
    modport master (
        output req1, base1, req2, base2, rom_data,
        input  gnt1, gnt2, rom_en, rom_addr, rd_data, rd_valid1, rd_valid2, rd_last, busy
    );

    // Arbiter side
    modport slave (
        input  req1, base1, req2, base2, rom_data,
        output gnt1, gnt2, rom_en, rom_addr, rd_data, rd_valid1, rd_valid2, rd_last, busy
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing the sprite-pixel ROM read port between two renderers.
// Each grant issues a BURST-word read starting at the latched base; returned data is
// tagged with its owner and last-word flag by a ROM_LAT-deep shift register.
module sprite_rom_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int BURST   = 8,
    parameter int ROM_LAT = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    sprite_rom_arbiter_if.slave  bus
);
    localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {IDLE, ISSUE} state_t;
    typedef enum logic {P1, P2} player_t;

    state_t            state;
    state_t            state_next;
    player_t           last_served;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] base_q;
    logic              grant1;
    logic              grant2;
    logic              issuing;
    logic              burst_done;

    // Owner bit in the return pipe: 0 = player 1, 1 = player 2
    logic [ROM_LAT-1:0] pipe_valid;
    logic [ROM_LAT-1:0] pipe_owner;
    logic [ROM_LAT-1:0] pipe_last;

    assign issuing    = (state == ISSUE);
    assign burst_done = (cnt == CNT_W'(BURST - 1));

    // Arbitration: requests are only looked at in IDLE; ties go to the player not served last
    always_comb begin
        grant1 = 1'b0;
        grant2 = 1'b0;
        if (state == IDLE && !reset) begin
            if (bus.req1 && (!bus.req2 || last_served == P2))
                grant1 = 1'b1;
            else if (bus.req2)
                grant2 = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant1 || grant2) state_next = ISSUE;
            ISSUE:   if (burst_done)       state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Burst bookkeeping: latch base and owner on grant, step the word counter while issuing
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            base_q      <= '0;
            last_served <= P2;
        end else begin
            if (grant1) begin
                base_q      <= bus.base1;
                last_served <= P1;
            end else if (grant2) begin
                base_q      <= bus.base2;
                last_served <= P2;
            end
            if (issuing)
                cnt <= burst_done ? '0 : cnt + 1'b1;
        end
    end

    // Return-tag pipeline, loaded every cycle so a tag emerges exactly ROM_LAT cycles after rom_en
    generate
        if (ROM_LAT > 1) begin : g_pipe_deep
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    pipe_valid <= '0;
                    pipe_owner <= '0;
                    pipe_last  <= '0;
                end else begin
                    pipe_valid <= {pipe_valid[ROM_LAT-2:0], issuing};
                    pipe_owner <= {pipe_owner[ROM_LAT-2:0], last_served == P2};
                    pipe_last  <= {pipe_last[ROM_LAT-2:0], issuing & burst_done};
                end
            end
        end else begin : g_pipe_single
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    pipe_valid <= '0;
                    pipe_owner <= '0;
                    pipe_last  <= '0;
                end else begin
                    pipe_valid <= issuing;
                    pipe_owner <= (last_served == P2);
                    pipe_last  <= issuing & burst_done;
                end
            end
        end
    endgenerate

    // Output decode
    always_comb begin
        bus.gnt1      = grant1;
        bus.gnt2      = grant2;
        bus.rom_en    = issuing;
        bus.rom_addr  = issuing ? base_q + ADDR_W'(cnt) : '0;
        bus.rd_data   = reset ? '0 : bus.rom_data;
        bus.rd_valid1 = pipe_valid[ROM_LAT-1] & ~pipe_owner[ROM_LAT-1];
        bus.rd_valid2 = pipe_valid[ROM_LAT-1] &  pipe_owner[ROM_LAT-1];
        bus.rd_last   = pipe_valid[ROM_LAT-1] &  pipe_last[ROM_LAT-1];
        bus.busy      = issuing | (|pipe_valid);
    end
endmodule
